// File: rtl/ula_pkg.sv
// Shared ALU definitions: control codes and multi-cycle sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ula_pkg;

  localparam logic [3:0] ULA_AND = 4'd0;
  localparam logic [3:0] ULA_OR  = 4'd1;
  localparam logic [3:0] ULA_ADD = 4'd2;
  localparam logic [3:0] ULA_SUB = 4'd3;
  localparam logic [3:0] ULA_MUL = 4'd4;
  localparam logic [3:0] ULA_DIV = 4'd5;
  localparam logic [3:0] ULA_SRL = 4'd6;
  localparam logic [3:0] ULA_SLL = 4'd7;
  localparam logic [3:0] ULA_NOR = 4'd8;
  localparam logic [3:0] ULA_BEQ = 4'd9;
  localparam logic [3:0] ULA_BLT = 4'd10;
  localparam logic [3:0] ULA_BGT = 4'd11;
  localparam logic [3:0] ULA_BNE = 4'd12;
  localparam logic [3:0] ULA_INV = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ula_multiciclo_ctrl_if.sv
// Execute-stage <-> multi-cycle ALU sequencer bundle.
// Latency: n/a (wiring only).
// Backpressure: stall from the sequencer holds the execute stage.
interface ula_multiciclo_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              start;
  logic [CTRL_W-1:0] sinal_controle;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  resultado;
  logic              overflow;
  logic              div_zero;

  modport master (
    output start, sinal_controle, op_a, op_b, flush,
    input  stall, busy, done, resultado, overflow, div_zero
  );

  modport slave (
    input  start, sinal_controle, op_a, op_b, flush,
    output stall, busy, done, resultado, overflow, div_zero
  );
endinterface

// File: rtl/mul_div_iterativo.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per step.
// Latency: WIDTH steps after load; next-state values are exposed combinationally.
// Backpressure: none; the controller decides when to load and step.
module mul_div_iterativo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             sel_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last_iter,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // hi: product high half / partial remainder; lo: multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;

  // One iteration of the selected algorithm; the MSB of div_diff is the borrow.
  always_comb begin
    hi_nxt   = hi_q;
    lo_nxt   = lo_q;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    if (sel_div) begin
      if (!div_diff[WIDTH]) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_rem[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand load on accept, then advance one bit per step; counter only moves here.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= sel_div ? op_a : op_b;
      opnd_q <= sel_div ? op_b : op_a;
      cnt_q  <= CNT_W'(WIDTH);
    end else if (step) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_iter = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ula_multiciclo_ctrl.sv
// Sequencer for multi-cycle mul/div beside the single-cycle ALU.
// Latency: done WIDTH+1 cycles after accept (1 cycle for divide by zero).
// Backpressure: stall held from the accept cycle through the last iteration.
module ula_multiciclo_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input logic                  clock,
  input logic                  reset,
  ula_multiciclo_ctrl_if.slave bus
);
  state_t           state_q, state_d;
  logic             is_mul, is_div, div_by_zero, accept;
  logic             load, step, sel_div, last_iter;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] resultado_q;
  logic             overflow_q, div_zero_q;

  assign is_mul      = (bus.sinal_controle == CTRL_W'(ULA_MUL));
  assign is_div      = (bus.sinal_controle == CTRL_W'(ULA_DIV));
  assign div_by_zero = is_div && (bus.op_b == '0);
  assign accept      = (state_q == IDLE) && bus.start && (is_mul || is_div) && !bus.flush;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath controls; flush abandons an iterating op silently.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    sel_div = (state_q == DIV);
    case (state_q)
      IDLE: begin
        sel_div = is_div;
        if (accept) begin
          if (is_mul) begin
            state_d = MUL;
            load    = 1'b1;
          end else if (div_by_zero) begin
            state_d = DONE;
          end else begin
            state_d = DIV;
            load    = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (bus.flush)      state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result/flag registers: cleared on accept, written on the final iteration only.
  always_ff @(posedge clock) begin
    if (reset) begin
      resultado_q <= '0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else if (accept) begin
      overflow_q <= 1'b0;
      div_zero_q <= div_by_zero;
      if (div_by_zero) resultado_q <= '1;
    end else if (step && last_iter && !bus.flush) begin
      resultado_q <= lo_nxt;
      if (state_q == MUL) overflow_q <= |hi_nxt;
    end
  end

  mul_div_iterativo #(.WIDTH(WIDTH)) u_dp (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .sel_div   (sel_div),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .last_iter (last_iter),
    .hi_nxt    (hi_nxt),
    .lo_nxt    (lo_nxt)
  );

  assign bus.busy      = (state_q == MUL) || (state_q == DIV);
  assign bus.stall     = accept || bus.busy;
  assign bus.done      = (state_q == DONE);
  assign bus.resultado = resultado_q;
  assign bus.overflow  = overflow_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_ula_multiciclo_ctrl.sv
// Directed bench for the multi-cycle mul/div sequencer.
// Latency: checks done/stall cycle positions against hand-computed values.
// Backpressure: stall observed every cycle of each scenario.
module tb_ula_multiciclo_ctrl;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ula_multiciclo_ctrl_if #(.WIDTH(32), .CTRL_W(4)) bus ();

  ula_multiciclo_ctrl #(.WIDTH(32), .CTRL_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op in cycle 0 and observe ncyc cycles; records observations only.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int ncyc, input bit hold,
                        output int done_first, output int done_cnt,
                        output int stall_cnt, output int stall_last);
    done_first = -1; done_cnt = 0; stall_cnt = 0; stall_last = -1;
    bus.start = 1'b1; bus.sinal_controle = code; bus.op_a = a; bus.op_b = b;
    for (int c = 0; c < ncyc; c++) begin
      #3;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
      end
      if (bus.stall === 1'b1) begin
        stall_cnt++;
        stall_last = c;
      end
      tick();
      if (!hold) bus.start = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #3;
    checks += 6;
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.stall !== 1'b0)     begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    if (bus.resultado !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 0", bus.resultado); end
    if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    if (bus.div_zero !== 1'b0)  begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_zero); end
    tick();
  endtask

  task automatic test_mul();
    int df, dc, sc, sl;
    run_op(4'd4, 32'd7, 32'd6, 40, 1'b0, df, dc, sc, sl);
    checks += 6;
    if (df !== 33) begin errors++; $display("FAIL mul_done_cycle got %0d want 33", df); end
    if (dc !== 1)  begin errors++; $display("FAIL mul_done_pulses got %0d want 1", dc); end
    if (sc !== 33) begin errors++; $display("FAIL mul_stall_cycles got %0d want 33", sc); end
    if (sl !== 32) begin errors++; $display("FAIL mul_stall_last got %0d want 32", sl); end
    if (bus.resultado !== 32'd42) begin errors++; $display("FAIL mul_res got %0d want 42", bus.resultado); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mul_ovf got %b want 0", bus.overflow); end
  endtask

  task automatic test_div();
    int df, dc, sc, sl;
    run_op(4'd5, 32'd100, 32'd7, 40, 1'b0, df, dc, sc, sl);
    checks += 4;
    if (df !== 33) begin errors++; $display("FAIL div_done_cycle got %0d want 33", df); end
    if (sc !== 33) begin errors++; $display("FAIL div_stall_cycles got %0d want 33", sc); end
    if (bus.resultado !== 32'd14) begin errors++; $display("FAIL div_res got %0d want 14", bus.resultado); end
    if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_dz got %b want 0", bus.div_zero); end
  endtask

  task automatic test_div_zero();
    int df, dc, sc, sl;
    run_op(4'd5, 32'd5, 32'd0, 8, 1'b0, df, dc, sc, sl);
    checks += 6;
    if (df !== 1) begin errors++; $display("FAIL dz_done_cycle got %0d want 1", df); end
    if (dc !== 1) begin errors++; $display("FAIL dz_done_pulses got %0d want 1", dc); end
    if (sc !== 1) begin errors++; $display("FAIL dz_stall_cycles got %0d want 1", sc); end
    if (sl !== 0) begin errors++; $display("FAIL dz_stall_last got %0d want 0", sl); end
    if (bus.resultado !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_res got %h want ffffffff", bus.resultado); end
    if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.div_zero); end
  endtask

  task automatic test_mul_overflow();
    int df, dc, sc, sl;
    run_op(4'd4, 32'h0001_0000, 32'h0001_0000, 40, 1'b0, df, dc, sc, sl);
    checks += 4;
    if (bus.resultado !== 32'h0) begin errors++; $display("FAIL ovf_res got %h want 0", bus.resultado); end
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL ovf_dz_cleared got %b want 0", bus.div_zero); end
    if (df !== 33) begin errors++; $display("FAIL ovf_done_cycle got %0d want 33", df); end
    run_op(4'd4, 32'd3, 32'd3, 40, 1'b0, df, dc, sc, sl);
    checks += 2;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", bus.overflow); end
    if (bus.resultado !== 32'd9) begin errors++; $display("FAIL mul3x3_res got %0d want 9", bus.resultado); end
  endtask

  // Flush a mul at cycle 10, then start div 9/3 in cycle 11.
  task automatic test_flush();
    int done_seen_early;
    int done_at;
    done_seen_early = 0;
    done_at = -1;
    for (int c = 0; c < 50; c++) begin
      bus.start = 1'b0; bus.flush = 1'b0;
      if (c == 0)  begin bus.start = 1'b1; bus.sinal_controle = 4'd4; bus.op_a = 32'd5; bus.op_b = 32'd5; end
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) begin bus.start = 1'b1; bus.sinal_controle = 4'd5; bus.op_a = 32'd9; bus.op_b = 32'd3; end
      #3;
      if (c <= 11 && bus.done === 1'b1) done_seen_early++;
      if (c > 11 && bus.done === 1'b1 && done_at < 0) done_at = c;
      if (c == 11) begin
        checks += 3;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", bus.busy); end
        if (bus.resultado !== 32'd9) begin errors++; $display("FAIL flush_res_kept got %0d want 9", bus.resultado); end
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_reaccept_stall got %b want 1", bus.stall); end
      end
      tick();
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    checks += 3;
    if (done_seen_early !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", done_seen_early); end
    if (done_at !== 44) begin errors++; $display("FAIL flush_div_done_cycle got %0d want 44", done_at); end
    if (bus.resultado !== 32'd3) begin errors++; $display("FAIL flush_div_res got %0d want 3", bus.resultado); end
  endtask

  // Flush beats start in IDLE.
  task automatic test_flush_idle();
    bus.start = 1'b1; bus.flush = 1'b1; bus.sinal_controle = 4'd4; bus.op_a = 32'd2; bus.op_b = 32'd2;
    #3;
    checks += 1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b want 0", bus.stall); end
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    #3;
    checks += 1;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", bus.busy); end
    tick();
  endtask

  // Flush arriving in DONE does not suppress the pulse.
  task automatic test_flush_done();
    int done_at;
    done_at = -1;
    for (int c = 0; c < 36; c++) begin
      bus.start = (c == 0); bus.flush = (c == 33);
      bus.sinal_controle = 4'd4; bus.op_a = 32'd2; bus.op_b = 32'd2;
      #3;
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
      tick();
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    checks += 2;
    if (done_at !== 33) begin errors++; $display("FAIL flush_done_pulse got %0d want 33", done_at); end
    if (bus.resultado !== 32'd4) begin errors++; $display("FAIL flush_done_res got %0d want 4", bus.resultado); end
  endtask

  // start held high: ignored while busy and in DONE, re-accepted in IDLE.
  task automatic test_back_to_back();
    int df, dc, sc, sl;
    run_op(4'd4, 32'd3, 32'd5, 68, 1'b1, df, dc, sc, sl);
    checks += 4;
    if (df !== 33) begin errors++; $display("FAIL b2b_first_done got %0d want 33", df); end
    if (dc !== 2)  begin errors++; $display("FAIL b2b_done_pulses got %0d want 2", dc); end
    if (sc !== 66) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 66", sc); end
    if (bus.resultado !== 32'd15) begin errors++; $display("FAIL b2b_res got %0d want 15", bus.resultado); end
    tick();
  endtask

  // Reset mid-divide, then a non-multicycle code must be ignored.
  task automatic test_reset_mid();
    int stall_seen, done_seen;
    stall_seen = 0; done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      bus.start = (c == 0); bus.sinal_controle = 4'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
      reset = (c == 5);
      tick();
    end
    reset = 1'b0;
    bus.start = 1'b1; bus.sinal_controle = 4'd2;
    #3;
    checks += 5;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    if (bus.resultado !== 32'h0) begin errors++; $display("FAIL rstmid_res got %h want 0", bus.resultado); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b want 0", bus.overflow); end
    if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL rstmid_dz got %b want 0", bus.div_zero); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) #3;
      if (bus.stall === 1'b1) stall_seen++;
      if (bus.done === 1'b1) done_seen++;
      tick();
    end
    bus.start = 1'b0;
    checks += 2;
    if (stall_seen !== 0) begin errors++; $display("FAIL add_stall got %0d want 0", stall_seen); end
    if (done_seen !== 0)  begin errors++; $display("FAIL add_done got %0d want 0", done_seen); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.sinal_controle = 4'd0;
    bus.op_a = 32'd0;
    bus.op_b = 32'd0;
    tick();
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mul_overflow();
    test_flush();
    test_flush_idle();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
